// File: rtl/stream_mux_pkg.sv
// Shared constants and round-robin pick helper for the stream_mux_rr family.
// Optional packet lock in the top is enabled by STREAM_MUX_PKT_LOCK_EN.
package stream_mux_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Upper bound on channel count handled by rr_pick; callers truncate the result.
  localparam int unsigned RR_MAX_CH = 64;
  localparam int unsigned RR_IDX_W  = $clog2(RR_MAX_CH);

  typedef logic [RR_MAX_CH-1:0] rr_vec_t;

  // One-hot grant of the first valid channel after ptr, wrapping at n_ch.
  function automatic rr_vec_t rr_pick(input rr_vec_t valid,
                                      input int unsigned ptr,
                                      input int unsigned n_ch);
    rr_vec_t               grant;
    logic                  found;
    int unsigned           sum;
    logic [RR_IDX_W-1:0]   idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= RR_MAX_CH; k++) begin
      if (k <= n_ch && !found) begin
        sum = ptr + k;
        if (sum >= n_ch) sum = sum - n_ch;
        idx = RR_IDX_W'(sum);
        if (valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant of the first valid channel after ptr.
// Independent of STREAM_MUX_PKT_LOCK_EN.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  localparam int unsigned SW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] valid,
  input  logic [SW-1:0]   ptr,
  output logic [N_CH-1:0] grant
);

  always_comb begin
    grant = N_CH'(rr_pick(RR_MAX_CH'(valid), 32'(ptr), N_CH));
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with explicit-select or round-robin arbitration
// and a registered output stage. STREAM_MUX_PKT_LOCK_EN adds LAST-delimited packet lock.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int unsigned N_CH = 4,
  parameter  int unsigned W    = 8,
  localparam int unsigned SW   = $clog2(N_CH)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MODE,
  input  logic [SW-1:0]     S,
  input  logic [N_CH-1:0]   A_VALID,
  input  logic [N_CH*W-1:0] A_DATA,
`ifdef STREAM_MUX_PKT_LOCK_EN
  input  logic [N_CH-1:0]   A_LAST,
  output logic              X_LAST,
`endif
  output logic [N_CH-1:0]   A_READY,
  output logic              X_VALID,
  output logic [W-1:0]      X_DATA,
  output logic [SW-1:0]     X_CHAN,
  input  logic              X_READY
);

  logic [SW-1:0]   ptr_q;
  logic            ld_c;
  logic [N_CH-1:0] rr_grant_c;
  logic [N_CH-1:0] sel_grant_c;
  logic [N_CH-1:0] grant_c;
  logic            xfer_c;
  logic [SW-1:0]   xfer_chan_c;
  logic [W-1:0]    xfer_data_c;
`ifdef STREAM_MUX_PKT_LOCK_EN
  logic            lock_q;
  logic [SW-1:0]   lock_chan_q;
  logic [N_CH-1:0] lock_grant_c;
  logic            xfer_last_c;
`endif

  assign ld_c = !X_VALID || X_READY;

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .valid (A_VALID),
    .ptr   (ptr_q),
    .grant (rr_grant_c)
  );

  // Out-of-range S matches no channel, so the select grant stays zero.
  always_comb begin
    sel_grant_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (S == SW'(i)) sel_grant_c[i] = A_VALID[i];
    end
  end

`ifdef STREAM_MUX_PKT_LOCK_EN
  always_comb begin
    lock_grant_c = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (lock_chan_q == SW'(i)) lock_grant_c[i] = A_VALID[i];
    end
  end
`endif

  always_comb begin
    grant_c = (MODE == MODE_RR) ? rr_grant_c : sel_grant_c;
`ifdef STREAM_MUX_PKT_LOCK_EN
    if (lock_q) grant_c = lock_grant_c;
`endif
  end

  assign A_READY = RST ? '0 : (grant_c & {N_CH{ld_c}});

  // Grant is already qualified by A_VALID, so any ready bit is a transfer.
  always_comb begin
    xfer_c      = |A_READY;
    xfer_chan_c = '0;
    xfer_data_c = '0;
`ifdef STREAM_MUX_PKT_LOCK_EN
    xfer_last_c = 1'b0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (A_READY[i]) begin
        xfer_chan_c = SW'(i);
        xfer_data_c = A_DATA[i*W +: W];
`ifdef STREAM_MUX_PKT_LOCK_EN
        xfer_last_c = A_LAST[i];
`endif
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      X_VALID     <= 1'b0;
      X_DATA      <= '0;
      X_CHAN      <= '0;
      ptr_q       <= SW'(N_CH - 1);
`ifdef STREAM_MUX_PKT_LOCK_EN
      X_LAST      <= 1'b0;
      lock_q      <= 1'b0;
      lock_chan_q <= '0;
`endif
    end else if (ld_c) begin
      X_VALID <= xfer_c;
      if (xfer_c) begin
        X_DATA <= xfer_data_c;
        X_CHAN <= xfer_chan_c;
        if (MODE == MODE_RR) ptr_q <= xfer_chan_c;
`ifdef STREAM_MUX_PKT_LOCK_EN
        X_LAST      <= xfer_last_c;
        lock_q      <= !xfer_last_c;
        lock_chan_q <= xfer_chan_c;
`endif
      end
    end
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised successor to the single-bit 2:1 combinational mux.
- Selects one of N_CH W-bit valid/ready input streams onto one registered output stream.
- Two modes: explicit select on S, or fair round-robin across requesting channels.
- Sits between multiple producers and one shared consumer (bus port, FIFO, serialiser).

Parameters:
- N_CH, 4, number of input channels (>=2)
- W, 8, data width per channel
- SW, $clog2(N_CH), select/channel-index width (derived, not overridden)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- MODE  in  1  0 = explicit select via S; 1 = round-robin
- S  in  SW  channel select, used when MODE=0
- A_VALID  in  N_CH  per-channel valid
- A_DATA  in  N_CH*W  channel i occupies bits [i*W +: W]
- A_READY  out  N_CH  per-channel ready
- X_VALID  out  1  output valid
- X_DATA  out  W  output data
- X_CHAN  out  SW  source channel of the current X_DATA
- X_READY  in  1  consumer ready

Behaviour:
- Reset (async assert, sync release): X_VALID=0, X_DATA=0, X_CHAN=0, round-robin pointer PTR=N_CH-1, so channel 0 has first priority. A_READY is combinational and reads 0 while RST=1.
- Load enable: LD = !X_VALID | X_READY. The output register accepts a beat only when LD=1.
- Grant, one-hot G, combinational:
  - MODE=0: G[S]=A_VALID[S]. If S>=N_CH, G=0 and nothing is accepted.
  - MODE=1: first i with A_VALID[i]=1, searching PTR+1, PTR+2, ... with wrap modulo N_CH. G=0 if no channel is valid.
- A_READY[i] = G[i] & LD. At most one A_READY bit is high per cycle.
- Transfer on a channel: A_VALID[i] & A_READY[i]. On that edge: X_DATA <= data of i, X_CHAN <= i, X_VALID <= 1, and in MODE=1 PTR <= i. PTR is unchanged in MODE=0.
- If LD=1 and no transfer occurs: X_VALID <= 0. X_DATA and X_CHAN hold their last values.
- If LD=0 (X_VALID=1 and X_READY=0): X_VALID, X_DATA and X_CHAN are held stable.
- Latency: 1 cycle from input transfer to X_VALID. Throughput 1 beat/cycle when X_READY is held high.
- Fairness: in MODE=1 with all channels valid, grants cycle 0,1,...,N_CH-1,0,... A channel waits at most N_CH-1 grants.
- MODE or S changes take effect the same cycle through the grant logic. No beat is lost or duplicated, because transfer requires the handshake.
- Async reset mid-stream drops any held beat and returns PTR to N_CH-1.
- Widths: X_CHAN is a zero-extended channel index. Pointer wrap is explicit (PTR==N_CH-1 → 0), so non-power-of-2 N_CH is supported.

Optional Feature:
- Macro: STREAM_MUX_PKT_LOCK_EN.
- Defined:
  - Adds ports A_LAST (in, N_CH) and X_LAST (out, 1; resets to 0).
  - After a transfer with A_LAST[i]=0, the grant locks to channel i in both modes, ignoring S and PTR, until a transfer from i with A_LAST[i]=1.
  - X_LAST is registered alongside X_DATA.
  - Async reset clears the lock.
- Undefined: no LAST ports; arbitration is per beat.

Decomposition:
- Shared package stream_mux_pkg:
  - mode constants MODE_SEL=1'b0, MODE_RR=1'b1
  - function rr_pick(valid vector, ptr) returning the one-hot grant
- One sub-module is natural: rr_arbiter (N_CH param; inputs valid and ptr; output one-hot grant), reusable elsewhere.
- The output register stays in the top module.

Test Plan:
- Reset → X_VALID=0, X_DATA=0, X_CHAN=0, A_READY=0 during RST=1. After release, MODE=1 with all channels valid: first grant is channel 0.
- MODE=0, S=2, A_VALID=4'b1111, A_DATA ch2=8'hA5, X_READY=1 → A_READY=4'b0100. Next cycle X_VALID=1, X_DATA=8'hA5, X_CHAN=2.
- MODE=1, A_VALID=4'b1111, X_READY=1 for 8 cycles → X_CHAN sequence 0,1,2,3,0,1,2,3 with no bubbles.
- MODE=1, A_VALID=4'b1010, X_READY=1 → X_CHAN alternates 1,3,1,3. Drop A_VALID[3] → X_CHAN stays 1 every cycle.
- Backpressure: X_VALID=1 with X_DATA=8'h3C; X_READY=0 for 3 cycles → A_READY=0 and X_DATA/X_CHAN stable. On X_READY=1, the next beat loads the following cycle.
- S=3 with N_CH=3 (MODE=0) → A_READY=0; X_VALID falls to 0 after the current beat drains.
- With STREAM_MUX_PKT_LOCK_EN: ch1 sends a 3-beat packet (LAST on beat 3) while ch0 and ch2 are valid → X_CHAN=1,1,1, then 2 (round-robin resumes from PTR=1).
